alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle.sv | 143 ++++++++++++++
 tb/tb_alu_multicycle.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Handshaked ALU: registered single-cycle ops plus iterative shift-add multiply
// and restoring divide, one step per clock, fixed DATA_WIDTH-cycle latency.
module alu_multicycle #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  op_a, op_b, acc_hi, acc_lo;
  logic          is_div, sel_hi, div0;

  logic [SW-1:0] shamt;
  logic [W-1:0]  simple_res;
  logic          is_iter;

  assign shamt   = SrcB[SW-1:0];
  assign is_iter = (Operation == 4'b1010) || (Operation == 4'b1011) ||
                   (Operation == 4'b1100) || (Operation == 4'b1101);

  always_comb begin
    simple_res = '0;
    case (Operation)
      4'b0000: simple_res = SrcA & SrcB;
      4'b0001: simple_res = SrcA | SrcB;
      4'b0010: simple_res = SrcA + SrcB;
      4'b0011: simple_res = SrcA - SrcB;
      4'b0100: simple_res = SrcA ^ SrcB;
      4'b0101: simple_res = SrcA >> shamt;
      4'b0110: simple_res = SrcA << shamt;
      4'b0111: simple_res = $signed(SrcA) >>> shamt;
      4'b1000: simple_res = W'(SrcA == SrcB);
      4'b1001: simple_res = SrcB;
      4'b1110: simple_res = W'($signed(SrcA) < $signed(SrcB));
      4'b1111: simple_res = W'(SrcA < SrcB);
      default: simple_res = '0;
    endcase
  end

  // Multiply keeps {hi,lo} as {partial product, remaining multiplier};
  // divide keeps {hi,lo} as {partial remainder, dividend/quotient}.
  logic [W:0]   mul_sum, trial, diff;
  logic [W-1:0] nxt_hi, nxt_lo, iter_res;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? op_a : {W{1'b0}})};
    trial   = {acc_hi, acc_lo[W-1]};
    diff    = trial - {1'b0, op_b};
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (is_div) begin
      nxt_hi = diff[W] ? trial[W-1:0] : diff[W-1:0];
      nxt_lo = {acc_lo[W-2:0], ~diff[W]};
    end else begin
      {nxt_hi, nxt_lo} = {mul_sum, acc_lo[W-1:1]};
    end
    iter_res = '0;
    case ({is_div, sel_hi})
      2'b00: iter_res = nxt_lo;
      2'b01: iter_res = nxt_hi;
      2'b10: iter_res = div0 ? {W{1'b1}} : nxt_lo;
      2'b11: iter_res = div0 ? op_a : nxt_hi;
      default: iter_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      is_div    <= 1'b0;
      sel_hi    <= 1'b0;
      div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          op_a     <= SrcA;
          op_b     <= SrcB;
          is_div   <= Operation[2];
          sel_hi   <= Operation[0];
          div0     <= (SrcB == '0);
          if (is_iter) begin
            state  <= BUSY;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= Operation[2] ? SrcA : SrcB;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            ALUResult <= simple_res;
            Zero      <= (simple_res == '0);
          end
        end
        // Divide-by-zero still runs all steps so latency never depends on data.
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ALUResult <= iter_res;
            Zero      <= (iter_res == '0);
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle against an arithmetic
// reference model, including latency, backpressure and mid-operation reset.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, Zero;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [3:0]  Operation;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    p  = 64'(a) * 64'(b);
    sh = b[4:0];
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a - b;
      4'h4: return a ^ b;
      4'h5: return a >> sh;
      4'h6: return a << sh;
      4'h7: return 32'($signed(a) >>> sh);
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'h9: return b;
      4'hA: return p[31:0];
      4'hB: return p[63:32];
      4'hC: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hD: return (b == 0) ? a : a % b;
      4'hE: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Issue one op, check latency/result/Zero, hold out_ready low for `hold` cycles, then retire it.
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int hold);
    int lat;
    bit rdy_low;
    int exp_lat;
    exp_lat = (op >= 4'hA && op <= 4'hD) ? 32 : 0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    in_valid = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 0; rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, ALUResult, exp);
    chk({tag, "_zero"}, 32'(Zero), 32'(exp == 0));
    if (exp_lat != 0) chk({tag, "_busy_ready"}, 32'(rdy_low), 32'd1);
    repeat (hold) @(posedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_retired"}, 32'({out_valid, in_ready}), 32'b01);
    chk({tag, "_kept"}, ALUResult, exp);
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a, b, exp; } vec_t;
  vec_t vecs[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; Operation = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    @(negedge clk); reset = 1'b0;

    vecs.push_back('{4'h1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F});
    vecs.push_back('{4'h3, 32'h0, 32'h1, 32'hFFFF_FFFF});
    vecs.push_back('{4'h8, 32'd5, 32'd5, 32'd1});
    vecs.push_back('{4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000});
    vecs.push_back('{4'h6, 32'd1, 32'd33, 32'd2});
    vecs.push_back('{4'h0, 32'hF0, 32'h0F, 32'd0});
    vecs.push_back('{4'h9, 32'h1234_5000, 32'hABCD_E000, 32'hABCD_E000});
    vecs.push_back('{4'hE, 32'hFFFF_FFFF, 32'd1, 32'd1});
    vecs.push_back('{4'hF, 32'hFFFF_FFFF, 32'd1, 32'd0});
    vecs.push_back('{4'hA, 32'd7, 32'd6, 32'd42});
    vecs.push_back('{4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{4'hC, 32'd100, 32'd7, 32'd14});
    vecs.push_back('{4'hD, 32'd100, 32'd7, 32'd2});
    vecs.push_back('{4'hC, 32'd5, 32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{4'hD, 32'd5, 32'd0, 32'd5});
    foreach (vecs[i]) run($sformatf("dir%0d_op%h", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // Backpressure: result held while out_ready low; a new request in DONE is ignored.
    @(negedge clk); in_valid = 1'b1; Operation = 4'h3; SrcA = 32'd10; SrcB = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        @(negedge clk); in_valid = 1'b1; Operation = 4'h2; SrcA = 32'd1; SrcB = 32'd1;
      end
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c), {ALUResult[29:0], out_valid, in_ready}, {30'd7, 2'b10});
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release", 32'({out_valid, in_ready}), 32'b01);
    chk("bp_kept", ALUResult, 32'd7);
    run("bp_next", 4'h4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 0);

    // Reset 10 cycles into a divide.
    @(negedge clk); in_valid = 1'b1; Operation = 4'hC; SrcA = 32'd1000; SrcB = 32'd9;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_state", 32'({out_valid, in_ready, Zero}), 32'b011);
    chk("midrst_result", ALUResult, 32'd0);
    @(negedge clk); reset = 1'b0;
    run("midrst_add", 4'h2, 32'd2, 32'd3, 32'd5, 0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) b = a;
      run($sformatf("rnd%0d_op%h", n, op), op, a, b, ref_alu(op, a, b), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
